tx_stream_arbiter: RTL and testbench

Shares a single UART transmitter between the column-result stream (32-bit partial sums, byte-serialised) and the row-result stream (east outputs) leaving the output FIFO stage. Each granted stream sends a burst of up to BURST_LEN bytes, optionally preceded by a header byte carrying the stream ID and burst length. The two streams alternate round-robin. It sits between the output FIFO design and one uart_tx instance, replacing the two-transmitter arrangement so that one serial pin carries all results.

---
 rtl/tx_arb_pkg.sv | 30 +++
 rtl/tx_arb_rr2.sv | 25 ++
 rtl/tx_stream_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tx_stream_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// tx_arb_pkg
// Shared types and helpers for tx_stream_arbiter.
//   arb_state_t   : arbiter FSM states
//   STREAM_ID_*   : stream identifier carried in the header MSB
//   hdr_pack()    : builds the header byte {stream_id, burst_len[6:0]}
// Optional feature macro (used by tx_stream_arbiter): TX_ARB_HEADER_EN
// ----------------------------------------------------------------------------
package tx_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StHdrWait,
        StData,
        StDataWait
    } arb_state_t;

    localparam logic STREAM_ID_COL = 1'b0;
    localparam logic STREAM_ID_ROW = 1'b1;

    // Burst length field width inside the header byte (max burst 127).
    localparam int unsigned W_BLEN = 7;

    function automatic logic [7:0] hdr_pack(input logic stream_id,
                                            input logic [W_BLEN-1:0] len);
        return {stream_id, len};
    endfunction

endpackage

// File: rtl/tx_arb_rr2.sv
// ----------------------------------------------------------------------------
// tx_arb_rr2
// Two-input round-robin picker (combinational).
//   i_req        : eligible flags, bit0 = col, bit1 = row
//   i_last_owner : stream served last (0 = col, 1 = row)
//   o_gnt        : one-hot pick, 2'b00 when nothing is eligible
// On a tie the stream that was not served last wins.
// ----------------------------------------------------------------------------
module tx_arb_rr2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last_owner ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tx_stream_arbiter
// Shares one uart_tx between the column-result and row-result FIFOs. Each
// grant sends a burst of min(level, BURST_LEN) bytes; streams alternate
// round-robin when both are loaded.
//
// Optional feature macro: TX_ARB_HEADER_EN
//   defined   : every burst is preceded by a header byte {stream_id, len[6:0]}
//   undefined : raw data bytes only, IDLE goes straight to DATA
//
// Ports
//   i_clk, i_rst_l            : clock, asynchronous active-low reset
//   i_col_level / i_col_data  : column FIFO fill level and FWFT head byte
//   o_col_pop                 : column FIFO pop strobe
//   i_row_level / i_row_data  : row FIFO fill level and FWFT head byte
//   o_row_pop                 : row FIFO pop strobe
//   o_tx_dv / o_tx_byte       : byte strobe and registered byte to uart_tx
//   i_tx_active / i_tx_done   : uart_tx status and byte-complete pulse
//   o_grant                   : one-hot owner, bit0 = col, bit1 = row
//   o_busy                    : high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module tx_stream_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned W_DATA    = 8,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned W_LVL     = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic [W_LVL-1:0]  i_col_level,
    input  logic [W_DATA-1:0] i_col_data,
    output logic              o_col_pop,
    input  logic [W_LVL-1:0]  i_row_level,
    input  logic [W_DATA-1:0] i_row_data,
    output logic              o_row_pop,
    output logic              o_tx_dv,
    output logic [W_DATA-1:0] o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic [1:0]        o_grant,
    output logic              o_busy
);

    localparam logic [W_LVL-1:0] LVL_CAP = W_LVL'(BURST_LEN);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_owner_q, last_owner_d;
    logic [W_BLEN-1:0] burst_len_q, burst_len_d;
    logic [W_BLEN-1:0] cnt_q, cnt_d;
    logic              tx_dv_q, tx_dv_d;
    logic [W_DATA-1:0] tx_byte_q, tx_byte_d;
    logic              col_pop_q, col_pop_d;
    logic              row_pop_q, row_pop_d;

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [W_LVL-1:0]  col_len;
    logic [W_LVL-1:0]  row_len;
    logic [W_DATA-1:0] head_byte;

    assign req[0]  = (i_col_level != '0);
    assign req[1]  = (i_row_level != '0);
    assign col_len = (i_col_level > LVL_CAP) ? LVL_CAP : i_col_level;
    assign row_len = (i_row_level > LVL_CAP) ? LVL_CAP : i_row_level;
    assign head_byte = grant_q[1] ? i_row_data : i_col_data;

    tx_arb_rr2 u_rr2 (
        .i_req        (req),
        .i_last_owner (last_owner_q),
        .o_gnt        (pick)
    );

`ifdef TX_ARB_HEADER_EN
    logic [7:0] hdr_byte;
    assign hdr_byte = hdr_pack(grant_q[1] ? STREAM_ID_ROW : STREAM_ID_COL, burst_len_q);
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        burst_len_d  = burst_len_q;
        cnt_d        = cnt_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        col_pop_d    = 1'b0;
        row_pop_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick != 2'b00) begin
                    grant_d     = pick;
                    // Latched once; later level changes cannot stretch the burst.
                    burst_len_d = W_BLEN'(pick[1] ? row_len : col_len);
                    cnt_d       = '0;
`ifdef TX_ARB_HEADER_EN
                    state_d     = StHdr;
`else
                    state_d     = StData;
`endif
                end
            end
`ifdef TX_ARB_HEADER_EN
            StHdr: begin
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = W_DATA'(hdr_byte);
                    state_d   = StHdrWait;
                end
            end
            StHdrWait: begin
                if (i_tx_done) begin
                    state_d = StData;
                end
            end
`endif
            StData: begin
                // i_tx_active gating also covers a byte left in flight by a reset.
                if (!i_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = head_byte;
                    col_pop_d = grant_q[0];
                    row_pop_d = grant_q[1];
                    cnt_d     = cnt_q + W_BLEN'(1);
                    state_d   = StDataWait;
                end
            end
            StDataWait: begin
                if (i_tx_done) begin
                    if (cnt_q == burst_len_q) begin
                        state_d      = StIdle;
                        grant_d      = 2'b00;
                        last_owner_d = grant_q[1];
                    end else begin
                        state_d = StData;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_owner_q <= STREAM_ID_ROW;  // col wins the first tie
            burst_len_q  <= '0;
            cnt_q        <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            col_pop_q    <= 1'b0;
            row_pop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            burst_len_q  <= burst_len_d;
            cnt_q        <= cnt_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            col_pop_q    <= col_pop_d;
            row_pop_q    <= row_pop_d;
        end
    end

    assign o_tx_dv   = tx_dv_q;
    assign o_tx_byte = tx_byte_q;
    assign o_col_pop = col_pop_q;
    assign o_row_pop = row_pop_q;
    assign o_grant   = grant_q;
    assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tx_stream_arbiter
// Bench for tx_stream_arbiter with BURST_LEN = 4. FIFO and uart_tx behaviour
// are modelled inside step(), which runs once per falling clock edge so all
// sampling and driving happens away from the active edge. Expected line
// content comes from a burst-schedule model; header bytes are expected only
// when TX_ARB_HEADER_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_stream_arbiter;

    localparam int unsigned W_DATA    = 8;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned W_LVL     = 10;
    localparam int          BYTE_T    = 10;
    localparam int          BUDGET    = 3000;

`ifdef TX_ARB_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_l;
    logic [W_LVL-1:0]  i_col_level;
    logic [W_DATA-1:0] i_col_data;
    logic              o_col_pop;
    logic [W_LVL-1:0]  i_row_level;
    logic [W_DATA-1:0] i_row_data;
    logic              o_row_pop;
    logic              o_tx_dv;
    logic [W_DATA-1:0] o_tx_byte;
    logic              i_tx_active;
    logic              i_tx_done;
    logic [1:0]        o_grant;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    tx_stream_arbiter #(
        .W_DATA    (W_DATA),
        .BURST_LEN (BURST_LEN),
        .W_LVL     (W_LVL)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_l     (i_rst_l),
        .i_col_level (i_col_level),
        .i_col_data  (i_col_data),
        .o_col_pop   (o_col_pop),
        .i_row_level (i_row_level),
        .i_row_data  (i_row_data),
        .o_row_pop   (o_row_pop),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    logic [7:0] col_q[$];
    logic [7:0] row_q[$];
    logic [7:0] exp_col[$];
    logic [7:0] exp_row[$];
    logic [7:0] exp_line[$];
    logic [7:0] line_q[$];

    int         uart_cnt;
    bit         hold_busy;
    bit         inj_done;
    int         col_pops;
    int         row_pops;
    int         bursts;
    logic [1:0] first_grant;
    logic [1:0] prev_grant;
    logic       model_last;
    logic [7:0] col_next;
    logic [7:0] row_next;
    int         errors;
    int         checks;

    typedef struct {
        int         nc;
        int         nr;
        logic [1:0] first;
        int         bursts;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        i_col_level = W_LVL'(col_q.size());
        i_row_level = W_LVL'(row_q.size());
        i_col_data  = (col_q.size() > 0) ? col_q[0] : 8'h00;
        i_row_data  = (row_q.size() > 0) ? row_q[0] : 8'h00;
        i_tx_active = (uart_cnt != 0) || hold_busy;
    endtask

    // One clock of the FIFO + uart_tx model, evaluated at the falling edge.
    task automatic step();
        @(negedge i_clk);
        i_tx_done = 1'b0;
        if (o_tx_dv) begin
            check("dv_while_uart_busy", 32'(i_tx_active), 32'd0);
            line_q.push_back(o_tx_byte);
            uart_cnt = BYTE_T;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) i_tx_done = 1'b1;
        end
        if (inj_done) begin
            i_tx_done = 1'b1;
            inj_done  = 1'b0;
        end
        if (o_col_pop) begin
            check("col_pop_grant_dv_nonempty",
                  32'({o_grant, o_tx_dv, col_q.size() > 0}), 32'd7);
            if (col_q.size() > 0) void'(col_q.pop_front());
            col_pops++;
        end
        if (o_row_pop) begin
            check("row_pop_grant_dv_nonempty",
                  32'({o_grant, o_tx_dv, row_q.size() > 0}), 32'd11);
            if (row_q.size() > 0) void'(row_q.pop_front());
            row_pops++;
        end
        if (o_grant != 2'b00 && prev_grant == 2'b00) begin
            bursts++;
            if (first_grant == 2'b00) first_grant = o_grant;
        end
        prev_grant = o_grant;
        drive();
    endtask

    task automatic load(input int nc, input int nr);
        for (int k = 0; k < nc; k++) begin
            col_q.push_back(col_next);
            exp_col.push_back(col_next);
            col_next = col_next + 8'd1;
        end
        for (int k = 0; k < nr; k++) begin
            row_q.push_back(row_next);
            exp_row.push_back(row_next);
            row_next = row_next + 8'd1;
        end
        drive();
    endtask

    // Burst schedule: alternate on ties, cap each burst at BURST_LEN.
    task automatic build_expected();
        int   n;
        logic own;
        while (exp_col.size() > 0 || exp_row.size() > 0) begin
            if (exp_col.size() > 0 && exp_row.size() > 0) own = ~model_last;
            else own = (exp_row.size() > 0);
            n = own ? exp_row.size() : exp_col.size();
            if (n > int'(BURST_LEN)) n = int'(BURST_LEN);
            if (HDR_EN) exp_line.push_back({own, 7'(n)});
            for (int k = 0; k < n; k++) begin
                if (own) exp_line.push_back(exp_row.pop_front());
                else exp_line.push_back(exp_col.pop_front());
            end
            model_last = own;
        end
    endtask

    task automatic compare_line(input string name);
        int n;
        check({name, "_line_len"}, 32'(line_q.size()), 32'(exp_line.size()));
        n = (line_q.size() < exp_line.size()) ? line_q.size() : exp_line.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(line_q[i]), 32'(exp_line[i]));
        end
        line_q.delete();
        exp_line.delete();
    endtask

    task automatic clear_counts();
        col_pops    = 0;
        row_pops    = 0;
        bursts      = 0;
        first_grant = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(col_q.size() == 0 && row_q.size() == 0 && !o_busy && uart_cnt == 0)
                   && k < BUDGET);
        check({name, "_completed_in_budget"}, 32'(k < BUDGET), 32'd1);
    endtask

    initial begin
        int  data_dvs;
        int  k;
        bit  dv_seen;

        errors = 0; checks = 0; uart_cnt = 0; hold_busy = 0; inj_done = 0;
        prev_grant = 2'b00; model_last = 1'b1; col_next = 8'hA1; row_next = 8'h51;
        clear_counts();
        i_tx_done = 1'b0;
        i_rst_l   = 1'b0;
        drive();

        vecs[0] = '{nc: 3, nr: 0, first: 2'b01, bursts: 1};
        vecs[1] = '{nc: 6, nr: 6, first: 2'b10, bursts: 4};
        vecs[2] = '{nc: 10, nr: 0, first: 2'b01, bursts: 3};
        vecs[3] = '{nc: 0, nr: 5, first: 2'b10, bursts: 2};
        vecs[4] = '{nc: 1, nr: 9, first: 2'b01, bursts: 4};
        vecs[5] = '{nc: 2, nr: 2, first: 2'b01, bursts: 2};

        // Reset state.
        repeat (3) step();
        check("rst_outputs", 32'({o_tx_dv, o_tx_byte, o_col_pop, o_row_pop, o_grant, o_busy}),
              32'd0);
        i_rst_l = 1'b1;
        step();
        check("rst_release_idle", 32'({o_grant, o_busy}), 32'd0);

        // Col only, with grant and first-strobe latency.
        clear_counts();
        load(3, 0);
        build_expected();
        step();
        check("lat_grant", 32'(o_grant), 32'd1);
        check("lat_busy_no_dv", 32'({o_busy, o_tx_dv}), 32'd2);
        step();
        check("lat_first_dv", 32'(o_tx_dv), 32'd1);
        check("lat_first_byte", 32'(o_tx_byte), HDR_EN ? 32'h03 : 32'hA1);
        wait_idle("col_only");
        check("col_only_pops", 32'({col_pops[7:0], row_pops[7:0]}), 32'h0300);
        check("col_only_grant_end", 32'(o_grant), 32'd0);
        compare_line("col_only");

        // UART busy after grant, with a stray done pulse in the waiting state.
        clear_counts();
        hold_busy = 1'b1;
        load(0, 2);
        build_expected();
        step();
        check("busy_grant", 32'(o_grant), 32'd2);
        dv_seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (c == 20) inj_done = 1'b1;
            dv_seen = dv_seen | o_tx_dv;
        end
        check("busy_no_dv_while_active", 32'(dv_seen), 32'd0);
        hold_busy = 1'b0;
        drive();
        step();
        check("busy_dv_one_cycle_after_release", 32'(o_tx_dv), 32'd1);
        wait_idle("busy");
        check("busy_pops", 32'({col_pops[7:0], row_pops[7:0]}), 32'h0002);
        compare_line("busy");

        // Reset mid-burst after the second data byte.
        clear_counts();
        load(6, 0);
        data_dvs = 0;
        k = 0;
        while (data_dvs < 2 && k < 200) begin
            step();
            k++;
            if (o_tx_dv && o_col_pop) data_dvs++;
        end
        check("rst_mid_reached_2nd_byte", 32'(data_dvs), 32'd2);
        #1 i_rst_l = 1'b0;
        #1;
        check("rst_mid_outputs_zero",
              32'({o_tx_dv, o_tx_byte, o_col_pop, o_row_pop, o_grant, o_busy}), 32'd0);
        col_q.delete(); row_q.delete(); exp_col.delete(); exp_row.delete();
        line_q.delete(); exp_line.delete();
        model_last = 1'b1;
        drive();
        repeat (2) step();
        i_rst_l = 1'b1;
        clear_counts();
        load(5, 2);
        build_expected();
        step();
        check("rst_mid_col_first", 32'(o_grant), 32'd1);
        wait_idle("rst_mid");
        check("rst_mid_pops", 32'({col_pops[7:0], row_pops[7:0]}), 32'h0502);
        compare_line("rst_mid");

        // Table-driven bursts (BURST_LEN = 4).
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            load(vecs[i].nc, vecs[i].nr);
            build_expected();
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_first_grant", i), 32'(first_grant), 32'(vecs[i].first));
            check($sformatf("vec%0d_bursts", i), 32'(bursts), 32'(vecs[i].bursts));
            check($sformatf("vec%0d_col_pops", i), 32'(col_pops), 32'(vecs[i].nc));
            check($sformatf("vec%0d_row_pops", i), 32'(row_pops), 32'(vecs[i].nr));
            check($sformatf("vec%0d_grant_end", i), 32'(o_grant), 32'd0);
            compare_line($sformatf("vec%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
